// File: rtl/clk_mon_pkg.sv
// Shared types for the toggle period monitor: FSM states and the captured
// half-period record.
package clk_mon_pkg;

   // Widest counter the measurement record can carry; CNT_W must not exceed it.
   localparam int MON_CNT_MAX_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MEAS  = 2'd1,
      STALL = 2'd2
   } mon_state_e;

   typedef struct packed {
      logic                     level;
      logic [MON_CNT_MAX_W-1:0] cnt;
   } mon_meas_t;

endpackage

// File: rtl/toggle_period_monitor_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a third flop that
// provides the pre-edge level and a one-cycle edge pulse.
module sync_edge_det (
   input  logic clock_i,
   input  logic rst_ni,
   input  logic sig_i,
   output logic toggle_o,
   output logic level_o
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clock_i) begin
      if (!rst_ni) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= sig_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign toggle_o = s2_q ^ s3_q;
   assign level_o  = s3_q;

endmodule

// File: rtl/toggle_period_monitor.sv
// Measures each half-period of an asynchronous toggling input in system clocks
// and streams the result, with sticky range/overflow flags and stall detection.
module toggle_period_monitor
   import clk_mon_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int MIN_HP  = 2,
   parameter int MAX_HP  = 1000,
   parameter int TIMEOUT = 4096
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             sig_in,
   input  logic             clear,
   output logic [CNT_W-1:0] m_tdata,
   output logic             m_tuser,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             err_range,
   output logic             overflow,
   output logic             stalled,
   output logic             locked
);

   mon_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] data_q, data_d;
   logic             user_q, user_d;
   logic             vld_q, vld_d;
   logic             err_q, err_d;
   logic             ovf_q, ovf_d;
   logic             stall_q, stall_d;
   logic             lock_q, lock_d;

   logic             sync_tgl, sync_lvl;
   logic             capture, stall_evt, stall_end;
   logic             drain, ovf_evt, range_bad;
   mon_meas_t        cap;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic in_range(input logic [MON_CNT_MAX_W-1:0] v);
      return (v >= MON_CNT_MAX_W'(MIN_HP)) && (v <= MON_CNT_MAX_W'(MAX_HP));
   endfunction

   sync_edge_det u_sync (
      .clock_i  (clock),
      .rst_ni   (rst_n),
      .sig_i    (sig_in),
      .toggle_o (sync_tgl),
      .level_o  (sync_lvl)
   );

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         user_q  <= 1'b0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         stall_q <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         user_q  <= user_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         stall_q <= stall_d;
         lock_q  <= lock_d;
      end
   end

   // Counter restarts at 1 on every edge so a capture equals the cycles between edges.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      capture   = 1'b0;
      stall_evt = 1'b0;
      stall_end = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync_tgl) begin
               state_d = MEAS;
               cnt_d   = CNT_W'(1);
            end
         end
         MEAS: begin
            if (sync_tgl) begin
               capture = 1'b1;
               cnt_d   = CNT_W'(1);
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               state_d   = STALL;
               stall_evt = 1'b1;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         STALL: begin
            if (sync_tgl) begin
               state_d   = MEAS;
               cnt_d     = CNT_W'(1);
               stall_end = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A capture may refill the slot in the same cycle it drains; otherwise a full slot drops it.
   always_comb begin
      cap     = '{level: sync_lvl, cnt: MON_CNT_MAX_W'(cnt_q)};
      drain   = vld_q && m_tready;
      data_d  = data_q;
      user_d  = user_q;
      vld_d   = vld_q;
      ovf_evt = 1'b0;
      if (capture) begin
         if (!vld_q || drain) begin
            data_d = cnt_q;
            user_d = cap.level;
            vld_d  = 1'b1;
         end else begin
            ovf_evt = 1'b1;
         end
      end else if (drain) begin
         vld_d = 1'b0;
      end

      range_bad = capture && !in_range(cap.cnt);
      err_d     = range_bad | (err_q & ~clear);
      ovf_d     = ovf_evt | (ovf_q & ~clear);

      stall_d = stall_q;
      if (clear || stall_end) stall_d = 1'b0;
      if (stall_evt)          stall_d = 1'b1;

      lock_d = lock_q;
      if (capture)                        lock_d = !range_bad;
      if (state_q != MEAS || stall_evt)   lock_d = 1'b0;
   end

   assign m_tdata   = data_q;
   assign m_tuser   = user_q;
   assign m_tvalid  = vld_q;
   assign err_range = err_q;
   assign overflow  = ovf_q;
   assign stalled   = stall_q;
   assign locked    = lock_q;

endmodule
